// File: rtl/gpu_clut_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gpu_clut_cache_pkg
// Brief   : Shared GPU constants, CLUT cache state type and chunk address helper.
// Revision: 1.0
// ============================================================================
package gpu_clut_cache_pkg;

    localparam int PIX_4BIT  = 0;
    localparam int PIX_8BIT  = 1;
    localparam int PIX_16BIT = 2;

    localparam int VRAM_WIDTH   = 1024;
    localparam int VRAM_HEIGHT  = 512;
    localparam int CLUT_ENTRIES = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FILL = 2'd2
    } clut_state_e;

    // Chunk column in halfwords; the 6-bit sum wraps the column inside the VRAM row.
    function automatic logic [9:0] chunk_col(input logic [5:0] x, input logic [3:0] chunk);
        logic [5:0] unit;
        unit = x + {2'b00, chunk};
        return {unit, 4'b0000};
    endfunction

endpackage
`default_nettype wire

// File: rtl/gpu_clut_cache_if.sv
`default_nettype none
// ============================================================================
// Module  : gpu_clut_cache_if
// Brief   : VRAM chunk-read bus between the CLUT cache and the memory arbiter.
// Revision: 1.0
// ============================================================================
interface gpu_clut_cache_if #(
    parameter int MEM_ADR_W = 19
);
    logic                 o_memReq;
    logic [MEM_ADR_W-1:0] o_memAdr;
    logic                 i_memAck;
    logic                 i_memValid;
    logic [31:0]          i_memData;

    modport master (
        output o_memReq, o_memAdr,
        input  i_memAck, i_memValid, i_memData
    );

    modport slave (
        input  o_memReq, o_memAdr,
        output i_memAck, i_memValid, i_memData
    );
endinterface
`default_nettype wire

// File: rtl/gpu_clut_ram.sv
`default_nettype none
// ============================================================================
// Module  : gpu_clut_ram
// Brief   : 256x16 palette store, one 32-bit (two-entry) write port, two registered reads.
// Revision: 1.0
// ============================================================================
module gpu_clut_ram
    import gpu_clut_cache_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        i_nrst,
    input  wire logic        i_we,
    input  wire logic [6:0]  i_wAdr,
    input  wire logic [31:0] i_wData,
    input  wire logic [7:0]  i_rAdr0,
    input  wire logic [7:0]  i_rAdr1,
    output logic      [15:0] o_rData0,
    output logic      [15:0] o_rData1
);

    logic [15:0] mem_q [CLUT_ENTRIES];
    logic [15:0] rd0_q;
    logic [15:0] rd1_q;

    always_ff @(posedge clk) begin
        if (i_we) begin
            mem_q[{i_wAdr, 1'b0}] <= i_wData[15:0];
            mem_q[{i_wAdr, 1'b1}] <= i_wData[31:16];
        end
    end

    // Reads sample the array before this edge's write lands: old data on a collision.
    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            rd0_q <= 16'h0000;
            rd1_q <= 16'h0000;
        end else begin
            rd0_q <= mem_q[i_rAdr0];
            rd1_q <= mem_q[i_rAdr1];
        end
    end

    assign o_rData0 = rd0_q;
    assign o_rData1 = rd1_q;

endmodule
`default_nettype wire

// File: rtl/gpu_clut_cache.sv
`default_nettype none
// ============================================================================
// Module  : gpu_clut_cache
// Brief   : Palette cache: chunked VRAM CLUT loads with residency tags, dual lookup.
// Revision: 1.0
// ============================================================================
module gpu_clut_cache
    import gpu_clut_cache_pkg::*;
#(
    parameter int MEM_ADR_W = 19
) (
    input  wire logic        clk,
    input  wire logic        i_nrst,
    input  wire logic        i_loadReq,
    input  wire logic [5:0]  i_clutX,
    input  wire logic [8:0]  i_clutY,
    input  wire logic        i_is8bit,
    input  wire logic        i_invalidate,
    output logic             o_ready,
    gpu_clut_cache_if.master mem,
    input  wire logic [7:0]  i_index0,
    input  wire logic [7:0]  i_index1,
    output logic      [15:0] o_color0,
    output logic      [15:0] o_color1
);

    clut_state_e state_q, state_d;
    logic        resident_q, resident_d;
    logic        kill_q, kill_d;
    logic [5:0]  tagX_q, tagX_d;
    logic [8:0]  tagY_q, tagY_d;
    logic        tag8bit_q, tag8bit_d;
    logic [3:0]  chunk_q, chunk_d;
    logic [3:0]  lastChunk_q, lastChunk_d;
    logic [2:0]  beat_q, beat_d;

    logic        hit_w;
    logic        we_w;

    // An invalidate arriving with the request wins, so it can never hit.
    assign hit_w = resident_q && !i_invalidate && (i_clutX == tagX_q) &&
                   (i_clutY == tagY_q) && (!i_is8bit || tag8bit_q);

    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q     <= ST_IDLE;
            resident_q  <= 1'b0;
            kill_q      <= 1'b0;
            tagX_q      <= 6'd0;
            tagY_q      <= 9'd0;
            tag8bit_q   <= 1'b0;
            chunk_q     <= 4'd0;
            lastChunk_q <= 4'd0;
            beat_q      <= 3'd0;
        end else begin
            state_q     <= state_d;
            resident_q  <= resident_d;
            kill_q      <= kill_d;
            tagX_q      <= tagX_d;
            tagY_q      <= tagY_d;
            tag8bit_q   <= tag8bit_d;
            chunk_q     <= chunk_d;
            lastChunk_q <= lastChunk_d;
            beat_q      <= beat_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        resident_d  = resident_q;
        kill_d      = kill_q;
        tagX_d      = tagX_q;
        tagY_d      = tagY_q;
        tag8bit_d   = tag8bit_q;
        chunk_d     = chunk_q;
        lastChunk_d = lastChunk_q;
        beat_d      = beat_q;
        case (state_q)
            ST_IDLE: begin
                if (i_invalidate) begin
                    resident_d = 1'b0;
                end
                if (i_loadReq && !hit_w) begin
                    tagX_d      = i_clutX;
                    tagY_d      = i_clutY;
                    tag8bit_d   = i_is8bit;
                    resident_d  = 1'b0;
                    kill_d      = 1'b0;
                    chunk_d     = 4'd0;
                    lastChunk_d = i_is8bit ? 4'd15 : 4'd0;
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                if (i_invalidate) begin
                    kill_d = 1'b1;
                end
                if (mem.i_memAck) begin
                    beat_d  = 3'd0;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (i_invalidate) begin
                    kill_d = 1'b1;
                end
                if (mem.i_memValid) begin
                    beat_d = beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        if (chunk_q == lastChunk_q) begin
                            resident_d = !(kill_q || i_invalidate);
                            state_d    = ST_IDLE;
                        end else begin
                            chunk_d = chunk_q + 4'd1;
                            state_d = ST_REQ;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign we_w         = (state_q == ST_FILL) && mem.i_memValid;
    assign o_ready      = (state_q == ST_IDLE);
    assign mem.o_memReq = (state_q == ST_REQ);
    assign mem.o_memAdr = MEM_ADR_W'({tagY_q, chunk_col(tagX_q, chunk_q)});

    gpu_clut_ram u_ram (
        .clk      (clk),
        .i_nrst   (i_nrst),
        .i_we     (we_w),
        .i_wAdr   ({chunk_q, beat_q}),
        .i_wData  (mem.i_memData),
        .i_rAdr0  (i_index0),
        .i_rAdr1  (i_index1),
        .o_rData0 (o_color0),
        .o_rData1 (o_color1)
    );

endmodule
`default_nettype wire

// File: tb/tb_gpu_clut_cache.sv
`default_nettype none
// ============================================================================
// Module  : tb_gpu_clut_cache
// Brief   : Randomised self-checking bench for gpu_clut_cache against a palette model.
// Revision: 1.0
// ============================================================================
module tb_gpu_clut_cache;

    logic        clk = 1'b0;
    logic        i_nrst;
    logic        i_loadReq;
    logic [5:0]  i_clutX;
    logic [8:0]  i_clutY;
    logic        i_is8bit;
    logic        i_invalidate;
    logic        o_ready;
    logic [7:0]  i_index0;
    logic [7:0]  i_index1;
    logic [15:0] o_color0;
    logic [15:0] o_color1;

    always #5 clk = ~clk;

    gpu_clut_cache_if #(.MEM_ADR_W(19)) mem ();

    gpu_clut_cache #(.MEM_ADR_W(19)) dut (
        .clk          (clk),
        .i_nrst       (i_nrst),
        .i_loadReq    (i_loadReq),
        .i_clutX      (i_clutX),
        .i_clutY      (i_clutY),
        .i_is8bit     (i_is8bit),
        .i_invalidate (i_invalidate),
        .o_ready      (o_ready),
        .mem          (mem.master),
        .i_index0     (i_index0),
        .i_index1     (i_index1),
        .o_color0     (o_color0),
        .o_color1     (o_color1)
    );

    int tests = 0;
    int fails = 0;

    // Palette model: contents, which entries are defined, and residency tags.
    logic [15:0] m_clut  [256];
    bit          m_known [256];
    bit          m_res;
    logic [5:0]  m_x;
    logic [8:0]  m_y;
    bit          m_8;

    bit          ovr;
    logic [7:0]  ovr0, ovr1;
    logic [31:0] last_data;
    logic [18:0] adr_log [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Index driver: random lookups unless the main sequence pins them.
    initial begin
        i_index0 = 8'd0;
        i_index1 = 8'd0;
        forever begin
            @(posedge clk);
            #1;
            if (ovr) begin
                i_index0 = ovr0;
                i_index1 = ovr1;
            end else begin
                i_index0 = 8'($urandom);
                i_index1 = 8'($urandom);
            end
        end
    end

    // Every settled idle cycle: colours must equal the model entry at the previous edge.
    initial begin
        bit          cap_v;
        bit          k0, k1;
        logic [15:0] e0, e1;
        cap_v = 1'b0;
        k0 = 1'b0; k1 = 1'b0; e0 = '0; e1 = '0;
        forever begin
            @(negedge clk);
            if (cap_v && i_nrst && o_ready) begin
                if (k0) check("color0", {16'h0, o_color0}, {16'h0, e0});
                if (k1) check("color1", {16'h0, o_color1}, {16'h0, e1});
            end
            cap_v = i_nrst && o_ready;
            e0 = m_clut[i_index0];
            k0 = m_known[i_index0];
            e1 = m_clut[i_index1];
            k1 = m_known[i_index1];
        end
    end

    // One load request acting as the VRAM slave. inv_at/rst_at are global beat numbers (-1: none).
    task automatic do_load(input logic [5:0] x, input logic [8:0] y, input bit b8,
                           input bit inv_with_req, input int inv_at, input int rst_at,
                           input bit pattern, output int reqs, output int beats);
        bit          hit, kill, ok;
        int          last, gbeat;
        logic [31:0] data;
        logic [18:0] exp_adr;
        reqs = 0; beats = 0; gbeat = 0; kill = 1'b0;
        hit = m_res && !inv_with_req && (x == m_x) && (y == m_y) && (!b8 || m_8);
        i_clutX = x; i_clutY = y; i_is8bit = b8;
        i_invalidate = inv_with_req; i_loadReq = 1'b1;
        tick;
        i_loadReq = 1'b0; i_invalidate = 1'b0;
        if (hit) begin
            ok = 1'b1;
            repeat (6) begin
                if (mem.o_memReq !== 1'b0 || o_ready !== 1'b1) ok = 1'b0;
                tick;
            end
            check("hit_no_traffic", {31'h0, ok}, 32'h1);
            return;
        end
        m_res = 1'b0; m_x = x; m_y = y; m_8 = b8;
        last = b8 ? 15 : 0;
        check("busy_on_miss", {31'h0, o_ready}, 32'h0);
        for (int c = 0; c <= last; c++) begin
            int n;
            n = 0;
            while (mem.o_memReq !== 1'b1 && n < 30) begin
                tick;
                n++;
            end
            tests++;
            if (mem.o_memReq !== 1'b1) begin
                fails++;
                $display("FAIL req_timeout: memReq=%b, expected 1 for chunk %0d", mem.o_memReq, c);
                return;
            end
            reqs++;
            exp_adr = {y, 10'((int'(x) * 16 + c * 16) % 1024)};
            adr_log[c] = mem.o_memAdr;
            check("mem_adr", {13'h0, mem.o_memAdr}, {13'h0, exp_adr});
            repeat ($urandom_range(0, 2)) tick;
            mem.i_memAck = 1'b1;
            tick;
            mem.i_memAck = 1'b0;
            check("req_drop", {31'h0, mem.o_memReq}, 32'h0);
            for (int b = 0; b < 8; b++) begin
                repeat ($urandom_range(0, 1)) tick;
                if (gbeat == rst_at) begin
                    i_nrst = 1'b0;
                    #1;
                    check("rst_ready", {31'h0, o_ready}, 32'h1);
                    check("rst_memreq", {31'h0, mem.o_memReq}, 32'h0);
                    tick;
                    i_nrst = 1'b1;
                    return;
                end
                data = pattern ? {16'(c * 16 + 2 * b + 1), 16'(c * 16 + 2 * b)} : $urandom;
                mem.i_memValid = 1'b1;
                mem.i_memData  = data;
                m_clut[c * 16 + 2 * b]      = data[15:0];
                m_clut[c * 16 + 2 * b + 1]  = data[31:16];
                m_known[c * 16 + 2 * b]     = 1'b1;
                m_known[c * 16 + 2 * b + 1] = 1'b1;
                last_data = data;
                if (gbeat == inv_at) begin
                    i_invalidate = 1'b1;
                    kill = 1'b1;
                end
                tick;
                mem.i_memValid = 1'b0;
                i_invalidate = 1'b0;
                beats++;
                gbeat++;
            end
            check("ready_after_chunk", {31'h0, o_ready}, (c == last) ? 32'h1 : 32'h0);
        end
        m_res = !kill;
    endtask

    task automatic lookup(input logic [7:0] a0, input logic [7:0] a1);
        ovr0 = a0; ovr1 = a1; ovr = 1'b1;
        tick;
        tick;
        ovr = 1'b0;
    endtask

    task automatic invalidate_idle;
        i_invalidate = 1'b1;
        tick;
        i_invalidate = 1'b0;
        m_res = 1'b0;
    endtask

    initial begin
        int reqs, beats;
        i_nrst = 1'b0; i_loadReq = 1'b0; i_clutX = '0; i_clutY = '0;
        i_is8bit = 1'b0; i_invalidate = 1'b0;
        mem.i_memAck = 1'b0; mem.i_memValid = 1'b0; mem.i_memData = '0;
        ovr = 1'b0; ovr0 = '0; ovr1 = '0; last_data = '0;
        m_res = 1'b0; m_x = '0; m_y = '0; m_8 = 1'b0;
        for (int i = 0; i < 256; i++) begin
            m_clut[i] = '0;
            m_known[i] = 1'b0;
        end
        tick;
        check("rst_ready0", {31'h0, o_ready}, 32'h1);
        check("rst_memreq0", {31'h0, mem.o_memReq}, 32'h0);
        check("rst_memadr0", {13'h0, mem.o_memAdr}, 32'h0);
        check("rst_color0", {16'h0, o_color0}, 32'h0);
        check("rst_color1", {16'h0, o_color1}, 32'h0);
        i_nrst = 1'b1;
        tick;

        // 4-bit miss with the 0x(2k+1)(2k) beat pattern.
        do_load(6'd2, 9'd480, 1'b0, 1'b0, -1, -1, 1'b1, reqs, beats);
        check("t1_reqs", reqs, 1);
        check("t1_beats", beats, 8);
        check("t1_adr", {13'h0, adr_log[0]}, 32'h0007_8020);
        lookup(8'd5, 8'd14);
        check("t1_idx5", {16'h0, o_color0}, 32'h0000_0005);
        check("t1_idx14", {16'h0, o_color1}, 32'h0000_000E);

        do_load(6'd2, 9'd480, 1'b0, 1'b0, -1, -1, 1'b0, reqs, beats);
        check("t2_hit_reqs", reqs, 0);
        do_load(6'd2, 9'd480, 1'b1, 1'b0, -1, -1, 1'b0, reqs, beats);
        check("t2_8b_reqs", reqs, 16);
        check("t2_8b_beats", beats, 128);

        // Column wrap inside row 0.
        do_load(6'd60, 9'd0, 1'b1, 1'b0, -1, -1, 1'b0, reqs, beats);
        check("t3_adr0", {13'h0, adr_log[0]}, 32'h0000_03C0);
        check("t3_adr3", {13'h0, adr_log[3]}, 32'h0000_03F0);
        check("t3_adr4", {13'h0, adr_log[4]}, 32'h0000_0000);
        check("t3_adr15", {13'h0, adr_log[15]}, 32'h0000_00B0);
        lookup(8'd0, 8'd255);
        check("t3_idx255", {16'h0, o_color1}, {16'h0, last_data[31:16]});
        check("dual_idx0", {16'h0, o_color0}, {16'h0, m_clut[0]});
        check("dual_idx255", {16'h0, o_color1}, {16'h0, m_clut[255]});

        // Invalidate during chunk 3 then the same request misses again.
        do_load(6'd10, 9'd100, 1'b1, 1'b0, 3 * 8 + 2, -1, 1'b0, reqs, beats);
        check("t4_beats", beats, 128);
        do_load(6'd10, 9'd100, 1'b1, 1'b0, -1, -1, 1'b0, reqs, beats);
        check("t4_reload_reqs", reqs, 16);
        do_load(6'd10, 9'd100, 1'b0, 1'b0, -1, -1, 1'b0, reqs, beats);
        check("t4_4b_hit", reqs, 0);

        // Invalidate in idle, and together with a request.
        invalidate_idle;
        do_load(6'd10, 9'd100, 1'b0, 1'b0, -1, -1, 1'b0, reqs, beats);
        check("t5_inv_miss", reqs, 1);
        do_load(6'd10, 9'd100, 1'b0, 1'b1, -1, -1, 1'b0, reqs, beats);
        check("t5_inv_req_miss", reqs, 1);

        // Reset during beat 4, then stray beats must not land.
        do_load(6'd7, 9'd3, 1'b0, 1'b0, -1, 4, 1'b0, reqs, beats);
        m_res = 1'b0;
        check("t6_ready", {31'h0, o_ready}, 32'h1);
        check("t6_memreq", {31'h0, mem.o_memReq}, 32'h0);
        repeat (3) begin
            mem.i_memValid = 1'b1;
            mem.i_memData = $urandom;
            tick;
        end
        mem.i_memValid = 1'b0;
        lookup(8'd2, 8'd9);
        check("t6_stray_idx2", {16'h0, o_color0}, {16'h0, m_clut[2]});
        check("t6_stray_idx9", {16'h0, o_color1}, {16'h0, m_clut[9]});
        do_load(6'd7, 9'd3, 1'b0, 1'b0, -1, -1, 1'b0, reqs, beats);
        check("t6_next_miss", reqs, 1);

        // Randomised traffic over a small tag space so hits and misses both occur.
        for (int it = 0; it < 24; it++) begin
            int          sel, inv_at;
            logic [5:0]  rx;
            logic [8:0]  ry;
            sel = int'($urandom_range(0, 9));
            if (sel == 0) begin
                invalidate_idle;
            end else begin
                rx = 6'($urandom_range(62, 64) % 64);
                ry = 9'($urandom_range(5, 6));
                inv_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : -1;
                do_load(rx, ry, 1'($urandom), ($urandom_range(0, 7) == 0), inv_at, -1,
                        1'b0, reqs, beats);
            end
            repeat ($urandom_range(1, 4)) tick;
        end

        repeat (4) tick;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
